edge_frame_ctrl: RTL and testbench

Frame-level sequencer for the grayscale/Sobel edge-detection pipeline. It admits exactly one frame of WIDTH*HEIGHT RGB pixels from a source into the pipeline input FIFO. It drains exactly WIDTH*HEIGHT grayscale edge pixels from the pipeline output FIFO to a sink through a one-entry output register. It reports busy, frame completion and a drain-stall timeout.

---
 rtl/edge_frame_ctrl.sv | 158 +++++++++++++++
 tb/tb_edge_frame_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/edge_frame_ctrl.sv
// Frame sequencer for the grayscale/Sobel edge pipeline: admits one frame of source
// pixels into the pipeline and drains exactly one frame of edge pixels to the sink.
module edge_frame_ctrl #(
  parameter int WIDTH          = 720,
  parameter int HEIGHT         = 540,
  parameter int DATA_WIDTH     = 24,
  parameter int TIMEOUT_CYCLES = 65535,
  localparam int TOTAL = WIDTH * HEIGHT,
  localparam int CW    = $clog2(TOTAL + 1),
  localparam int OW    = DATA_WIDTH / 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  src_valid,
  input  logic [DATA_WIDTH-1:0] src_data,
  output logic                  src_ready,
  output logic                  pipe_wr_en,
  output logic [DATA_WIDTH-1:0] pipe_din,
  input  logic                  pipe_full,
  input  logic                  pipe_out_empty,
  output logic                  pipe_out_rd_en,
  input  logic [OW-1:0]         pipe_out_dout,
  output logic                  sink_valid,
  output logic [OW-1:0]         sink_data,
  input  logic                  sink_ready,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  error,
  output logic [CW-1:0]         in_count,
  output logic [CW-1:0]         out_count
);

  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TOTAL_C   = CW'(TOTAL);
  localparam logic [CW-1:0] LAST_C    = CW'(TOTAL - 1);
  localparam logic [CW-1:0] ONE_C     = CW'(1);
  localparam logic [WW-1:0] TIMEOUT_C = WW'(TIMEOUT_CYCLES);
  localparam logic [WW-1:0] WD_ONE_C  = WW'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_DRAIN = 3'd2,
    S_DONE  = 3'd3,
    S_ERROR = 3'd4
  } state_t;

  state_t          state_r;
  logic [CW-1:0]   in_count_r;
  logic [CW-1:0]   out_count_r;
  logic [WW-1:0]   wd_r;
  logic            sink_valid_r;
  logic [OW-1:0]   sink_data_r;
  logic            busy_r;
  logic            frame_done_r;
  logic            error_r;

  logic            active_s;
  logic            src_ready_s;
  logic            wr_s;
  logic            room_s;
  logic            load_s;
  logic            hs_s;

  // The word already held in the output register counts against the frame, so
  // nothing beyond the last pixel of this frame is ever popped.
  assign active_s    = (state_r == S_RUN) || (state_r == S_DRAIN);
  assign src_ready_s = (state_r == S_RUN) && !pipe_full && (in_count_r < TOTAL_C);
  assign wr_s        = src_valid && src_ready_s;
  assign room_s      = ({1'b0, out_count_r} + {{CW{1'b0}}, sink_valid_r}) < {1'b0, TOTAL_C};
  assign load_s      = active_s && !pipe_out_empty && room_s && (!sink_valid_r || sink_ready);
  assign hs_s        = sink_valid_r && sink_ready;

  assign src_ready      = src_ready_s;
  assign pipe_wr_en     = wr_s;
  assign pipe_din       = src_data;
  assign pipe_out_rd_en = load_s;
  assign sink_valid     = sink_valid_r;
  assign sink_data      = sink_data_r;
  assign busy           = busy_r;
  assign frame_done     = frame_done_r;
  assign error          = error_r;
  assign in_count       = in_count_r;
  assign out_count      = out_count_r;

  // Frame FSM together with the counters, watchdog and output register it controls.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r      <= S_IDLE;
      in_count_r   <= {CW{1'b0}};
      out_count_r  <= {CW{1'b0}};
      wd_r         <= {WW{1'b0}};
      sink_valid_r <= 1'b0;
      sink_data_r  <= {OW{1'b0}};
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
      error_r      <= 1'b0;
    end else begin
      frame_done_r <= 1'b0;
      if (wr_s) begin
        in_count_r <= in_count_r + ONE_C;
      end
      if (hs_s) begin
        out_count_r <= out_count_r + ONE_C;
      end
      if (load_s) begin
        sink_valid_r <= 1'b1;
        sink_data_r  <= pipe_out_dout;
      end else if (hs_s) begin
        sink_valid_r <= 1'b0;
      end

      case (state_r)
        S_IDLE, S_ERROR: begin
          if (start) begin
            state_r     <= S_RUN;
            in_count_r  <= {CW{1'b0}};
            out_count_r <= {CW{1'b0}};
            wd_r        <= {WW{1'b0}};
            busy_r      <= 1'b1;
            error_r     <= 1'b0;
          end
        end
        S_RUN: begin
          if (wr_s && (in_count_r == LAST_C)) begin
            state_r <= S_DRAIN;
            wd_r    <= {WW{1'b0}};
          end
        end
        S_DRAIN: begin
          // The output side may already have finished while input was still arriving.
          if ((out_count_r == TOTAL_C) || (hs_s && (out_count_r == LAST_C))) begin
            state_r      <= S_DONE;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b1;
          end else if (wd_r == TIMEOUT_C) begin
            state_r      <= S_ERROR;
            busy_r       <= 1'b0;
            error_r      <= 1'b1;
            sink_valid_r <= 1'b0;
          end else if (hs_s) begin
            wd_r <= {WW{1'b0}};
          end else begin
            wd_r <= wd_r + WD_ONE_C;
          end
        end
        S_DONE: begin
          state_r <= S_IDLE;
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_edge_frame_ctrl.sv
// Bench for edge_frame_ctrl: table of whole-frame scenarios with a pipeline/FIFO model
// and an output scoreboard, plus hand-written reset and drain-timeout sequences.
module tb_edge_frame_ctrl;

  localparam int WIDTH          = 4;
  localparam int HEIGHT         = 3;
  localparam int DATA_WIDTH     = 24;
  localparam int TIMEOUT_CYCLES = 16;
  localparam int CW             = 4;
  localparam int OW             = 8;

  logic                  clock;
  logic                  reset;
  logic                  start;
  logic                  src_valid;
  logic [DATA_WIDTH-1:0] src_data;
  logic                  src_ready;
  logic                  pipe_wr_en;
  logic [DATA_WIDTH-1:0] pipe_din;
  logic                  pipe_full;
  logic                  pipe_out_empty;
  logic                  pipe_out_rd_en;
  logic [OW-1:0]         pipe_out_dout;
  logic                  sink_valid;
  logic [OW-1:0]         sink_data;
  logic                  sink_ready;
  logic                  busy;
  logic                  frame_done;
  logic                  error;
  logic [CW-1:0]         in_count;
  logic [CW-1:0]         out_count;

  edge_frame_ctrl #(
    .WIDTH(WIDTH), .HEIGHT(HEIGHT), .DATA_WIDTH(DATA_WIDTH), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clock(clock), .reset(reset), .start(start),
    .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
    .pipe_wr_en(pipe_wr_en), .pipe_din(pipe_din), .pipe_full(pipe_full),
    .pipe_out_empty(pipe_out_empty), .pipe_out_rd_en(pipe_out_rd_en), .pipe_out_dout(pipe_out_dout),
    .sink_valid(sink_valid), .sink_data(sink_data), .sink_ready(sink_ready),
    .busy(busy), .frame_done(frame_done), .error(error),
    .in_count(in_count), .out_count(out_count)
  );

  typedef struct {
    logic [15:0] full_mask;
    logic [3:0]  ready_pat;
    int          prefill;
    int          exp_wr;
    int          exp_hs;
    int          exp_in;
    int          exp_out;
    int          exp_done;
    int          exp_left;
  } vec_t;

  vec_t vecs[6];

  int n_vec = 0;
  int n_err = 0;
  int cyc_cnt = 0;

  logic [OW-1:0] ofifo[$];
  logic [OW-1:0] expq[$];
  int wr_cnt = 0, hs_cnt = 0, done_cnt = 0, viol = 0, gen_cnt = 0, pf_done = 0;
  int gen_limit;
  int pf_target;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc_cnt <= cyc_cnt + 1;

  function automatic logic [OW-1:0] gray(input logic [DATA_WIDTH-1:0] p);
    return p[23:16] ^ p[15:8] ^ p[7:0] ^ 8'h5a;
  endfunction

  task automatic check(input string name, input int act, input int exp_v);
    n_vec++;
    if (act != exp_v) begin
      n_err++;
      $display("FAIL %s: actual %0d, required %0d", name, act, exp_v);
    end
  endtask

  // Pipeline + output FIFO model and sink scoreboard; samples on the falling edge,
  // applies FIFO effects just after the rising edge.
  initial begin : model
    logic s_wr, s_rd, s_hs, p_stall, p_rd;
    logic [DATA_WIDTH-1:0] s_pix;
    logic [OW-1:0] s_dout, p_sd, p_dout, tmp;
    s_wr = 1'b0; s_rd = 1'b0; p_stall = 1'b0; p_rd = 1'b0;
    s_pix = '0; s_dout = '0; p_sd = '0; p_dout = '0;
    pipe_out_empty = 1'b1;
    pipe_out_dout  = '0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        s_wr = 1'b0; s_rd = 1'b0; p_stall = 1'b0; p_rd = 1'b0;
      end else begin
        s_wr   = pipe_wr_en;
        s_pix  = src_data;
        s_rd   = pipe_out_rd_en;
        s_dout = pipe_out_dout;
        s_hs   = sink_valid & sink_ready;
        if (pipe_full && (src_ready || pipe_wr_en)) viol++;
        if (s_rd && pipe_out_empty) viol++;
        if (sink_valid && !sink_ready && s_rd) viol++;
        if (p_stall && (!sink_valid || sink_data !== p_sd)) viol++;
        if (p_rd && (!sink_valid || sink_data !== p_dout)) viol++;
        if (s_wr) wr_cnt++;
        if (frame_done) begin
          done_cnt++;
          if (busy) viol++;
        end
        if (s_hs) begin
          hs_cnt++;
          if (expq.size() == 0) viol++;
          else check("sink_data", sink_data, expq.pop_front());
        end
        p_stall = sink_valid & !sink_ready;
        p_sd    = sink_data;
        p_rd    = s_rd;
        p_dout  = s_dout;
      end
      @(posedge clock);
      #1;
      if (!reset) begin
        ofifo.delete();
        expq.delete();
      end else begin
        if (s_rd && ofifo.size() > 0) tmp = ofifo.pop_front();
        if (s_wr && gen_cnt < gen_limit) begin
          ofifo.push_back(gray(s_pix));
          expq.push_back(gray(s_pix));
          gen_cnt++;
        end
        while (pf_done < pf_target) begin
          tmp = OW'($urandom);
          ofifo.push_back(tmp);
          expq.push_back(tmp);
          pf_done++;
        end
      end
      #1;
      pipe_out_empty = (ofifo.size() == 0);
      pipe_out_dout  = (ofifo.size() == 0) ? 8'h00 : ofifo[0];
    end
  end

  task automatic check_outputs_zero(input string pfx);
    check({pfx, "_src_ready"}, src_ready, 0);
    check({pfx, "_pipe_wr_en"}, pipe_wr_en, 0);
    check({pfx, "_pipe_out_rd_en"}, pipe_out_rd_en, 0);
    check({pfx, "_sink_valid"}, sink_valid, 0);
    check({pfx, "_sink_data"}, sink_data, 0);
    check({pfx, "_busy"}, busy, 0);
    check({pfx, "_frame_done"}, frame_done, 0);
    check({pfx, "_error"}, error, 0);
    check({pfx, "_in_count"}, in_count, 0);
    check({pfx, "_out_count"}, out_count, 0);
  endtask

  task automatic run_frame(input vec_t v, input int idx);
    int b_wr, b_hs, b_done, b_viol, n;
    logic w;
    b_wr = wr_cnt; b_hs = hs_cnt; b_done = done_cnt; b_viol = viol;
    if (v.prefill > 0) begin
      gen_limit = gen_cnt;
      pf_target = pf_target + v.prefill;
    end else begin
      gen_limit = 1 << 30;
    end
    @(posedge clock); #3;
    @(posedge clock); #3;
    start = 1'b1;
    src_valid = 1'b1;
    src_data = DATA_WIDTH'($urandom);
    n = 0;
    for (int c = 0; c < 200; c++) begin
      pipe_full  = (c < 16) ? v.full_mask[c] : 1'b0;
      sink_ready = v.ready_pat[c % 4];
      @(negedge clock);
      w = pipe_wr_en;
      @(posedge clock); #3;
      start = 1'b0;
      if (w) src_data = DATA_WIDTH'($urandom);
      if (done_cnt != b_done) n++;
      if (n == 3) break;
    end
    @(negedge clock);
    check($sformatf("v%0d_src_ready_after", idx), src_ready, 0);
    check($sformatf("v%0d_wr_pulses", idx), wr_cnt - b_wr, v.exp_wr);
    check($sformatf("v%0d_handshakes", idx), hs_cnt - b_hs, v.exp_hs);
    check($sformatf("v%0d_done_pulses", idx), done_cnt - b_done, v.exp_done);
    check($sformatf("v%0d_in_count", idx), in_count, v.exp_in);
    check($sformatf("v%0d_out_count", idx), out_count, v.exp_out);
    check($sformatf("v%0d_busy", idx), busy, 0);
    check($sformatf("v%0d_out_empty", idx), pipe_out_empty, (v.exp_left == 0) ? 1 : 0);
    check($sformatf("v%0d_words_left", idx), expq.size(), v.exp_left);
    check($sformatf("v%0d_protocol", idx), viol - b_viol, 0);
    @(posedge clock); #3;
    src_valid = 1'b0;
    pipe_full = 1'b0;
  endtask

  initial begin : main
    int found, b_hs, hs_edge, err_edge;
    reset = 1'b0; start = 1'b0; src_valid = 1'b1; src_data = 24'h123456;
    pipe_full = 1'b0; sink_ready = 1'b1;
    gen_limit = 1 << 30;
    pf_target = 0;

    vecs[0] = '{16'h0000, 4'b1111, 0,  12, 12, 12, 12, 1, 0};
    vecs[1] = '{16'h0078, 4'b1111, 0,  12, 12, 12, 12, 1, 0};
    vecs[2] = '{16'h0000, 4'b1001, 0,  12, 12, 12, 12, 1, 0};
    vecs[3] = '{16'h0f0f, 4'b0110, 0,  12, 12, 12, 12, 1, 0};
    vecs[4] = '{16'h0000, 4'b1111, 14, 12, 12, 12, 12, 1, 2};
    vecs[5] = '{16'h0000, 4'b1111, 0,  12, 12, 12, 12, 1, 2};

    repeat (3) @(posedge clock);
    #1;
    check_outputs_zero("por");
    src_valid = 1'b0;
    @(negedge clock); #2 reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("por_idle_busy", busy, 0);
    check("por_idle_src_ready", src_ready, 0);

    for (int i = 0; i < 6; i++) run_frame(vecs[i], i);

    // Asynchronous reset in the middle of a frame.
    gen_limit = 1 << 30;
    @(posedge clock); #3;
    start = 1'b1; src_valid = 1'b1; sink_ready = 1'b0; pipe_full = 1'b0;
    @(posedge clock); #3;
    start = 1'b0;
    found = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      if (in_count == 4'd5) begin
        found = 1;
        break;
      end
      @(posedge clock); #3;
      src_data = DATA_WIDTH'($urandom);
    end
    check("rst_reached_in5", found, 1);
    #2 reset = 1'b0;
    #1;
    check_outputs_zero("rst_mid");
    repeat (2) @(posedge clock);
    @(negedge clock); #2 reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_after_busy", busy, 0);
    check("rst_after_src_ready", src_ready, 0);
    check("rst_after_in_count", in_count, 0);

    // Drain timeout: only 7 output words ever appear; sink opens after DRAIN entry.
    gen_limit = gen_cnt + 7;
    b_hs = hs_cnt;
    @(posedge clock); #3;
    start = 1'b1;
    @(posedge clock); #3;
    start = 1'b0;
    found = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      if (in_count == 4'd12) begin
        found = 1;
        break;
      end
      @(posedge clock); #3;
      src_data = DATA_WIDTH'($urandom);
    end
    check("to_reached_drain", found, 1);
    @(posedge clock); #3;
    sink_ready = 1'b1;
    src_valid = 1'b0;
    hs_edge = -1000;
    err_edge = -1;
    for (int c = 0; c < 80; c++) begin
      @(negedge clock);
      // A handshake seen here completes on the next rising edge; error seen here
      // rose on the edge just passed.
      if (sink_valid && sink_ready) hs_edge = cyc_cnt + 1;
      if (error) begin
        err_edge = cyc_cnt;
        break;
      end
    end
    check("to_handshakes", hs_cnt - b_hs, 7);
    check("to_error_latency", err_edge - hs_edge, 17);
    src_valid = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("to_error_sticky", error, 1);
    check("to_error_busy", busy, 0);
    check("to_error_sink_valid", sink_valid, 0);
    check("to_error_src_ready", src_ready, 0);
    check("to_error_rd_en", pipe_out_rd_en, 0);
    @(posedge clock); #3;
    src_valid = 1'b0;
    start = 1'b1;
    @(posedge clock); #3;
    start = 1'b0;
    @(negedge clock);
    check("to_restart_error", error, 0);
    check("to_restart_busy", busy, 1);
    check("to_restart_in_count", in_count, 0);
    check("to_restart_out_count", out_count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
